instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/instruction_fetch.sv | 77 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and default widths.
package cpu_pkg;
  localparam int         ADDR_W      = 6;
  localparam int         DATA_W      = 32;
  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry packet buffer between the fetch engine and decode.
module fetch_fifo #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;

  assign full   = (r_cnt == 2'd2);
  assign empty  = (r_cnt == 2'd0);
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rp];
  assign w_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= wdata;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch engine: pc/issue control, halt/redirect FSM, and a 2-deep packet buffer to decode.
module instruction_fetch #(
  parameter int         ADDR_W      = cpu_pkg::ADDR_W,
  parameter int         DATA_W      = cpu_pkg::DATA_W,
  parameter logic [5:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted
);
  import cpu_pkg::*;

  fetch_state_t             r_state;
  logic [ADDR_W-1:0]        r_pc, r_inflight_pc;
  logic                     r_inflight;
  logic                     w_empty, w_full, w_pop, w_push, w_halt_in, w_issue;
  logic [1:0]               w_count;
  logic [2:0]               w_occ;
  logic [DATA_W+ADDR_W-1:0] w_head;

  assign if_valid  = !w_empty;
  assign w_pop     = if_valid && if_ready && !redirect_valid;
  assign w_halt_in = r_inflight && (imem_instr[DATA_W-1 -: 6] == HALT_OPCODE);
  assign w_push    = r_inflight && !redirect_valid && (!w_full || w_pop);
  // Slots committed after this edge: buffered minus leaving plus arriving.
  assign w_occ     = {1'b0, w_count} - {2'b0, w_pop} + {2'b0, r_inflight};
  assign w_issue   = (r_state == RUN) && !w_halt_in && (w_occ < 3'd2);

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;
  assign halted    = (r_state == HALTED);
  assign {if_instr, if_pc} = w_head;

  fetch_fifo #(.W(DATA_W + ADDR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata ({imem_instr, r_inflight_pc}),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_state    <= RUN;
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight    <= w_issue;
      r_inflight_pc <= r_pc;
      if (w_issue) r_pc <= r_pc + ADDR_W'(1);
      case (r_state)
        IDLE:    r_state <= RUN;
        RUN:     if (w_halt_in) r_state <= HALTED;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule
